// File: rtl/vga_console_writer.sv
// Byte-stream console writer for the 98x36 text video RAM: cursor, control codes, clear, wrap.
// Optional macro VGA_CONSOLE_SCROLL_EN: bottom-row overflow scrolls the screen instead of wrapping to row 0.
module vga_console_writer #(
    parameter logic [31:0] BASE_ADDR  = 32'h0003_0000,
    parameter int          COLS       = 98,
    parameter int          ROWS       = 36,
    parameter bit          CLR_ON_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_char,
    output logic [5:0]  o_row,
    output logic [6:0]  o_col,
    output logic        o_busy,
    output logic        rd_req,
    input  logic        rd_gnt,
    output logic [31:0] rd_addr,
    input  logic [31:0] rd_data,
    output logic        wr_req,
    input  logic        wr_gnt,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_be
);

    localparam logic [11:0] COLS_W    = 12'(COLS);
    localparam logic [11:0] LAST_CELL = 12'(ROWS * COLS - 1);
    localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
    localparam logic [7:0]  SPACE     = 8'h20;

`ifdef VGA_CONSOLE_SCROLL_EN
    localparam logic [11:0] SCRL_LAST = 12'((ROWS - 1) * COLS - 1);
    typedef enum logic [2:0] {
        IDLE = 3'd0, WRITE = 3'd1, ADV_ROW = 3'd2, CLR_ROW = 3'd3, CLR_ALL = 3'd4,
        SCRL_RD = 3'd5, SCRL_WAIT = 3'd6, SCRL_WR = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0, WRITE = 3'd1, ADV_ROW = 3'd2, CLR_ROW = 3'd3, CLR_ALL = 3'd4
    } state_t;
`endif

    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    state_t      state_r, state_nx_s;
    logic [5:0]  row_r, row_nx_s;
    logic [6:0]  col_r, col_nx_s;
    logic [11:0] ptr_r, ptr_nx_s;
    logic [7:0]  char_r, char_nx_s;
    logic [11:0] cursor_idx_s, row_base_s;
    logic        accept_s, wr_done_s;
    logic        wr_req_nx_s;
    logic [31:0] wr_addr_nx_s, wr_data_nx_s;
    logic [3:0]  wr_be_nx_s;

    assign row_base_s   = {6'd0, row_r} * COLS_W;
    assign cursor_idx_s = row_base_s + {5'd0, col_r};
    assign accept_s     = i_valid & o_ready;
    assign wr_done_s    = wr_req & wr_gnt;
    assign o_row        = row_r;
    assign o_col        = col_r;

`ifdef VGA_CONSOLE_SCROLL_EN
    logic [11:0] rd_idx_s, rd_idx_nx_s;
    logic        rd_req_nx_s;
    logic [31:0] rd_addr_nx_s;
    assign rd_idx_s = ptr_r + COLS_W;
`else
    logic unused_s;
    assign unused_s = ^{rd_gnt, rd_data};
    assign rd_req   = 1'b0;
    assign rd_addr  = 32'd0;
`endif

    // State and cursor/datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= CLR_ON_RST ? CLR_ALL : IDLE;
            row_r   <= 6'd0;
            col_r   <= 7'd0;
            ptr_r   <= 12'd0;
            char_r  <= SPACE;
        end else begin
            state_r <= state_nx_s;
            row_r   <= row_nx_s;
            col_r   <= col_nx_s;
            ptr_r   <= ptr_nx_s;
            char_r  <= char_nx_s;
        end
    end

    // Next-state, cursor and cell-pointer decode
    always_comb begin
        state_nx_s = state_r;
        row_nx_s   = row_r;
        col_nx_s   = col_r;
        ptr_nx_s   = ptr_r;
        char_nx_s  = char_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    state_nx_s = IDLE;
                end else if (i_char >= 8'h20) begin
                    char_nx_s  = i_char;
                    ptr_nx_s   = cursor_idx_s;
                    state_nx_s = WRITE;
                end else begin
                    case (i_char)
                        8'h0A: begin
                            col_nx_s   = 7'd0;
                            state_nx_s = ADV_ROW;
                        end
                        8'h0D: col_nx_s = 7'd0;
                        8'h08: begin
                            if (col_r != 7'd0) col_nx_s = col_r - 7'd1;
                            else               col_nx_s = col_r;
                        end
                        8'h0C: begin
                            row_nx_s   = 6'd0;
                            col_nx_s   = 7'd0;
                            ptr_nx_s   = 12'd0;
                            char_nx_s  = SPACE;
                            state_nx_s = CLR_ALL;
                        end
                        default: state_nx_s = IDLE;
                    endcase
                end
            end
            WRITE: begin
                if (!wr_done_s) begin
                    state_nx_s = WRITE;
                end else if (col_r == LAST_COL) begin
                    col_nx_s   = 7'd0;
                    state_nx_s = ADV_ROW;
                end else begin
                    col_nx_s   = col_r + 7'd1;
                    state_nx_s = IDLE;
                end
            end
            ADV_ROW: begin
                if (row_r < LAST_ROW) begin
                    row_nx_s   = row_r + 6'd1;
                    state_nx_s = IDLE;
                end else begin
`ifdef VGA_CONSOLE_SCROLL_EN
                    ptr_nx_s   = 12'd0;
                    state_nx_s = SCRL_RD;
`else
                    row_nx_s   = 6'd0;
                    ptr_nx_s   = 12'd0;
                    char_nx_s  = SPACE;
                    state_nx_s = CLR_ROW;
`endif
                end
            end
            CLR_ROW: begin
                if (!wr_done_s)                                   state_nx_s = CLR_ROW;
                else if (ptr_r == row_base_s + {5'd0, LAST_COL})  state_nx_s = IDLE;
                else                                              ptr_nx_s   = ptr_r + 12'd1;
            end
            CLR_ALL: begin
                if (!wr_done_s) begin
                    state_nx_s = CLR_ALL;
                end else if (ptr_r == LAST_CELL) begin
                    row_nx_s   = 6'd0;
                    col_nx_s   = 7'd0;
                    state_nx_s = IDLE;
                end else begin
                    ptr_nx_s   = ptr_r + 12'd1;
                end
            end
`ifdef VGA_CONSOLE_SCROLL_EN
            SCRL_RD: begin
                if (rd_req && rd_gnt) state_nx_s = SCRL_WAIT;
                else                  state_nx_s = SCRL_RD;
            end
            SCRL_WAIT: begin
                char_nx_s  = lane_byte(rd_data, rd_idx_s[1:0]);
                state_nx_s = SCRL_WR;
            end
            SCRL_WR: begin
                if (!wr_done_s) begin
                    state_nx_s = SCRL_WR;
                end else if (ptr_r == SCRL_LAST) begin
                    ptr_nx_s   = SCRL_LAST + 12'd1;
                    char_nx_s  = SPACE;
                    state_nx_s = CLR_ROW;
                end else begin
                    ptr_nx_s   = ptr_r + 12'd1;
                    state_nx_s = SCRL_RD;
                end
            end
`endif
            default: state_nx_s = IDLE;
        endcase
    end

    // Bus request values derived from the upcoming state so they can be registered
    always_comb begin
        case (state_nx_s)
            WRITE, CLR_ROW, CLR_ALL: wr_req_nx_s = 1'b1;
`ifdef VGA_CONSOLE_SCROLL_EN
            SCRL_WR:                 wr_req_nx_s = 1'b1;
`endif
            default:                 wr_req_nx_s = 1'b0;
        endcase
        wr_addr_nx_s = BASE_ADDR + {20'd0, ptr_nx_s[11:2], 2'b00};
        wr_be_nx_s   = lane_be(ptr_nx_s[1:0]);
        wr_data_nx_s = {4{char_nx_s}};
`ifdef VGA_CONSOLE_SCROLL_EN
        rd_req_nx_s  = (state_nx_s == SCRL_RD);
        rd_idx_nx_s  = ptr_nx_s + COLS_W;
        rd_addr_nx_s = BASE_ADDR + {20'd0, rd_idx_nx_s[11:2], 2'b00};
`endif
    end

    // Registered handshake and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ready <= 1'b0;
            o_busy  <= CLR_ON_RST;
            wr_req  <= 1'b0;
            wr_addr <= 32'd0;
            wr_data <= 32'd0;
            wr_be   <= 4'd0;
`ifdef VGA_CONSOLE_SCROLL_EN
            rd_req  <= 1'b0;
            rd_addr <= 32'd0;
`endif
        end else begin
            o_ready <= (state_nx_s == IDLE);
            o_busy  <= (state_nx_s != IDLE);
            wr_req  <= wr_req_nx_s;
            wr_addr <= wr_addr_nx_s;
            wr_data <= wr_data_nx_s;
            wr_be   <= wr_be_nx_s;
`ifdef VGA_CONSOLE_SCROLL_EN
            rd_req  <= rd_req_nx_s;
            rd_addr <= rd_addr_nx_s;
`endif
        end
    end

endmodule
